// File: rtl/pkg_rv32_types.sv
// pkg_rv32_types: bus-owner states and AHB HTRANS encodings shared by the arbiter.
package pkg_rv32_types;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_t;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

endpackage

// File: rtl/rv32_ahb_arbiter.sv
// rv32_ahb_arbiter: two-master (CPU/DMA) AHB-lite arbiter with DMA priority and unsplittable bursts.
// Define RV32_ARB_FAIRNESS_EN to cap DMA tenure at MAX_DMA_BEATS beats while the CPU is waiting.
module rv32_ahb_arbiter
    import pkg_rv32_types::*;
#(
    parameter int XLEN          = 32,
    parameter int MAX_DMA_BEATS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic [XLEN-1:0] cpu_haddr,
    input  logic [1:0]      cpu_htrans,
    input  logic            cpu_hwrite,
    input  logic [2:0]      cpu_hsize,
    input  logic [XLEN-1:0] cpu_hwdata,
    input  logic            dma_req,
    input  logic [XLEN-1:0] dma_haddr,
    input  logic [1:0]      dma_htrans,
    input  logic            dma_hwrite,
    input  logic [2:0]      dma_hsize,
    input  logic [XLEN-1:0] dma_hwdata,
    input  logic            HREADY,
    output logic [XLEN-1:0] HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [XLEN-1:0] HWDATA,
    output logic            cpu_grant,
    output logic            dma_grant,
    output logic            dma_stall
);

    owner_t          state, state_nx, data_owner;
    logic [XLEN-1:0] haddr_q;
    logic            hwrite_q;
    logic [2:0]      hsize_q;
    logic            cpu_seq, dma_seq, quota_hit;

    assign cpu_seq = cpu_htrans == HT_SEQ;
    assign dma_seq = dma_htrans == HT_SEQ;

`ifdef RV32_ARB_FAIRNESS_EN
    localparam int CW = $clog2(MAX_DMA_BEATS + 1);
    logic [CW-1:0] beats;

    assign quota_hit = beats >= CW'(MAX_DMA_BEATS);

    always_ff @(posedge clk) begin
        if (rst) beats <= '0;
        else if (HREADY) beats <= state_nx != OWN_DMA ? '0 :
                                  (state == OWN_DMA && dma_htrans[1] && !quota_hit) ? beats + CW'(1) : beats;
    end
`else
    logic unused_cfg;

    assign quota_hit  = 1'b0;
    assign unused_cfg = MAX_DMA_BEATS > 0;
`endif

    // Handover only on a non-SEQ beat so a running burst is never split.
    always_comb begin
        state_nx = state;
        if (HREADY) begin
            unique case (state)
                OWN_IDLE: state_nx = dma_req ? OWN_DMA : cpu_req ? OWN_CPU : OWN_IDLE;
                OWN_CPU:  if (!cpu_seq) state_nx = dma_req ? OWN_DMA : cpu_req ? OWN_CPU : OWN_IDLE;
                OWN_DMA:  if (!dma_seq) state_nx = (quota_hit && cpu_req) ? OWN_CPU :
                                                   dma_req ? OWN_DMA : cpu_req ? OWN_CPU : OWN_IDLE;
                default:  state_nx = OWN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OWN_IDLE;
            data_owner <= OWN_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= '0;
        end else begin
            if (HREADY) begin
                state      <= state_nx;
                data_owner <= state;
            end
            if (state != OWN_IDLE) begin
                haddr_q  <= HADDR;
                hwrite_q <= HWRITE;
                hsize_q  <= HSIZE;
            end
        end
    end

    assign cpu_grant = state == OWN_CPU;
    assign dma_grant = state == OWN_DMA;
    assign HADDR     = cpu_grant ? cpu_haddr  : dma_grant ? dma_haddr  : haddr_q;
    assign HTRANS    = cpu_grant ? cpu_htrans : dma_grant ? dma_htrans : HT_IDLE;
    assign HWRITE    = cpu_grant ? cpu_hwrite : dma_grant ? dma_hwrite : hwrite_q;
    assign HSIZE     = cpu_grant ? cpu_hsize  : dma_grant ? dma_hsize  : hsize_q;
    assign HWDATA    = data_owner == OWN_CPU ? cpu_hwdata : data_owner == OWN_DMA ? dma_hwdata : '0;
    assign dma_stall = dma_grant | (data_owner == OWN_DMA);

endmodule

// File: tb/tb_rv32_ahb_arbiter.sv
// tb_rv32_ahb_arbiter: scoreboard bench; each cycle's expected bus view is queued with its stimulus.
module tb_rv32_ahb_arbiter;

    localparam logic [31:0] CPU_WD = 32'hCCCC_0001;
    localparam logic [31:0] DMA_WD = 32'hDDDD_0002;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, dma_req, cpu_hwrite, dma_hwrite, HREADY;
    logic [31:0] cpu_haddr, dma_haddr, cpu_hwdata, dma_hwdata;
    logic [1:0]  cpu_htrans, dma_htrans;
    logic [2:0]  cpu_hsize, dma_hsize;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, cpu_grant, dma_grant, dma_stall;
    logic [2:0]  HSIZE;

    typedef struct {
        logic [1:0]  g;
        logic        stall;
        logic [1:0]  tr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string phase;

    always #5 clk = ~clk;

    rv32_ahb_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_haddr(cpu_haddr), .cpu_htrans(cpu_htrans),
        .cpu_hwrite(cpu_hwrite), .cpu_hsize(cpu_hsize), .cpu_hwdata(cpu_hwdata),
        .dma_req(dma_req), .dma_haddr(dma_haddr), .dma_htrans(dma_htrans),
        .dma_hwrite(dma_hwrite), .dma_hsize(dma_hsize), .dma_hwdata(dma_hwdata),
        .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA),
        .cpu_grant(cpu_grant), .dma_grant(dma_grant), .dma_stall(dma_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Queue the expected post-edge view for the inputs currently driven, clock once, then compare.
    task automatic step(input logic [1:0] g, input logic stall, input logic [1:0] tr,
                        input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        sb.push_back('{g: g, stall: stall, tr: tr, addr: addr, wdata: wdata});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({phase, ".grants"}, {30'd0, cpu_grant, dma_grant}, {30'd0, e.g});
        check({phase, ".stall"},  {31'd0, dma_stall}, {31'd0, e.stall});
        check({phase, ".htrans"}, {30'd0, HTRANS}, {30'd0, e.tr});
        check({phase, ".haddr"},  HADDR, e.addr);
        check({phase, ".hwdata"}, HWDATA, e.wdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; HREADY = 1'b0;
        cpu_req = 1'b1; cpu_haddr = 32'h0; cpu_htrans = 2'b10; cpu_hwrite = 1'b0;
        cpu_hsize = 3'b010; cpu_hwdata = CPU_WD;
        dma_req = 1'b1; dma_haddr = 32'h0; dma_htrans = 2'b10; dma_hwrite = 1'b0;
        dma_hsize = 3'b010; dma_hwdata = DMA_WD;

        phase = "reset";
        step(2'b00, 0, 2'b00, 32'h0, 32'h0);
        check("reset.hsize", {29'd0, HSIZE}, 32'd0);
        check("reset.hwrite", {31'd0, HWRITE}, 32'd0);
        rst = 1'b0; HREADY = 1'b1; cpu_req = 0; dma_req = 0; cpu_htrans = 2'b00; dma_htrans = 2'b00;
        phase = "idle";
        step(2'b00, 0, 2'b00, 32'h0, 32'h0);

        phase = "lone_cpu";
        cpu_req = 1; cpu_haddr = 32'h100; cpu_htrans = 2'b10;
        step(2'b10, 0, 2'b10, 32'h100, 32'h0);
        cpu_req = 0; cpu_htrans = 2'b00;
        step(2'b00, 0, 2'b00, 32'h100, CPU_WD);
        step(2'b00, 0, 2'b00, 32'h100, 32'h0);

        phase = "both_req";
        cpu_req = 1; cpu_haddr = 32'h200; cpu_htrans = 2'b10;
        dma_req = 1; dma_haddr = 32'h3000; dma_htrans = 2'b10;
        step(2'b01, 1, 2'b10, 32'h3000, 32'h0);
        cpu_req = 0; cpu_htrans = 2'b00; dma_req = 0; dma_htrans = 2'b00;
        step(2'b00, 1, 2'b00, 32'h3000, DMA_WD);
        step(2'b00, 0, 2'b00, 32'h3000, 32'h0);

        phase = "incr4";
        cpu_req = 1; cpu_haddr = 32'h400; cpu_htrans = 2'b10;
        step(2'b10, 0, 2'b10, 32'h400, 32'h0);
        step(2'b10, 0, 2'b10, 32'h400, CPU_WD);
        cpu_htrans = 2'b11; cpu_haddr = 32'h404;
        dma_req = 1; dma_haddr = 32'h5000; dma_htrans = 2'b10;
        step(2'b10, 0, 2'b11, 32'h404, CPU_WD);
        cpu_haddr = 32'h408;
        step(2'b10, 0, 2'b11, 32'h408, CPU_WD);
        cpu_haddr = 32'h40C;
        step(2'b10, 0, 2'b11, 32'h40C, CPU_WD);
        cpu_req = 0; cpu_htrans = 2'b00;
        step(2'b01, 1, 2'b10, 32'h5000, CPU_WD);

        phase = "dma_wait";
        dma_req = 0; dma_haddr = 32'h2000; dma_hwrite = 1;
        step(2'b00, 1, 2'b00, 32'h2000, DMA_WD);
        check("dma_wait.hwrite_held", {31'd0, HWRITE}, 32'd1);
        dma_htrans = 2'b00; HREADY = 0;
        for (int i = 0; i < 3; i++) step(2'b00, 1, 2'b00, 32'h2000, DMA_WD);
        phase = "idle_hold";
        cpu_req = 1; cpu_haddr = 32'h600; cpu_htrans = 2'b10;
        step(2'b00, 1, 2'b00, 32'h2000, DMA_WD);
        cpu_req = 0; cpu_htrans = 2'b00; HREADY = 1;
        phase = "dma_done";
        step(2'b00, 0, 2'b00, 32'h2000, 32'h0);

        phase = "rst_mid_burst";
        dma_hwrite = 0; dma_req = 1; dma_haddr = 32'h7000; dma_htrans = 2'b10;
        step(2'b01, 1, 2'b10, 32'h7000, 32'h0);
        dma_haddr = 32'h7004; dma_htrans = 2'b11;
        step(2'b01, 1, 2'b11, 32'h7004, DMA_WD);
        rst = 1; HREADY = 0; dma_haddr = 32'h7008;
        step(2'b00, 0, 2'b00, 32'h0, 32'h0);
        rst = 0; HREADY = 1; dma_req = 0; dma_htrans = 2'b00;
        step(2'b00, 0, 2'b00, 32'h0, 32'h0);

`ifdef RV32_ARB_FAIRNESS_EN
        phase = "fairness";
        dma_req = 1; dma_haddr = 32'h8000; dma_htrans = 2'b10;
        cpu_req = 1; cpu_haddr = 32'h900; cpu_htrans = 2'b10;
        step(2'b01, 1, 2'b10, 32'h8000, 32'h0);
        step(2'b01, 1, 2'b10, 32'h8000, DMA_WD);
        for (int i = 1; i < 16; i++) step(2'b01, 1, 2'b10, 32'h8000, DMA_WD);
        step(2'b10, 1, 2'b10, 32'h900, DMA_WD);
        step(2'b01, 1, 2'b10, 32'h8000, CPU_WD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32_ahb_arbiter.md
RV32_AHB_ARBITER -- requirements
Module: rv32_ahb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address and data width.
REQ-002 Parameter MAX_DMA_BEATS, default 16, DMA beat quota before forced handover (fairness build only).
REQ-003 clk  input  1  single clock, all flops rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU master bus request.
REQ-006 cpu_haddr  input  XLEN  CPU address.
REQ-007 cpu_htrans  input  2  CPU HTRANS.
REQ-008 cpu_hwrite  input  1  CPU HWRITE.
REQ-009 cpu_hsize  input  3  CPU HSIZE.
REQ-010 cpu_hwdata  input  XLEN  CPU write data.
REQ-011 dma_req  input  1  DMA master bus request.
REQ-012 dma_haddr  input  XLEN  DMA address.
REQ-013 dma_htrans  input  2  DMA HTRANS.
REQ-014 dma_hwrite  input  1  DMA HWRITE.
REQ-015 dma_hsize  input  3  DMA HSIZE.
REQ-016 dma_hwdata  input  XLEN  DMA write data.
REQ-017 HREADY  input  1  shared bus ready.
REQ-018 HADDR, HTRANS, HWRITE, HSIZE  output  XLEN/2/1/3  muxed address phase.
REQ-019 HWDATA  output  XLEN  muxed data phase.
REQ-020 cpu_grant  output  1  CPU owns the address phase.
REQ-021 dma_grant  output  1  DMA owns the address phase.
REQ-022 dma_stall  output  1  core stall; high while DMA owns either phase.

Function
REQ-023 Owner FSM states: IDLE, CPU, DMA, registered; cpu_grant = (state==CPU), dma_grant = (state==DMA).
REQ-024 All state, counter and data-owner registers hold while HREADY=0.
REQ-025 IDLE with HREADY=1: dma_req goes to DMA; otherwise cpu_req goes to CPU; otherwise stay in IDLE.
REQ-026 CPU with HREADY=1 and cpu_htrans!=SEQ: dma_req goes to DMA (DMA has priority); otherwise !cpu_req goes to IDLE.
REQ-027 DMA with HREADY=1 and dma_htrans!=SEQ: !dma_req goes to CPU if cpu_req, else IDLE.
REQ-028 Ownership never changes while the owner drives SEQ, so a burst is never split.
REQ-029 Grant latency is 1 cycle: a request sampled with HREADY=1 at edge N is granted after edge N.
REQ-030 Address mux follows state; in IDLE, HTRANS=IDLE(00) and HADDR, HWRITE and HSIZE hold their last values.
REQ-031 data_owner is loaded from state on every edge with HREADY=1; HWDATA is muxed by data_owner.
REQ-032 dma_stall = dma_grant | (data_owner==DMA).
REQ-033 Simultaneous cpu_req and dma_req from IDLE: DMA wins.

Reset
REQ-034 While rst is high: state=IDLE, data_owner=NONE, beat counter=0, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, both grants 0, dma_stall=0.
REQ-035 Reset asserted mid-burst aborts the burst; the next edge yields the REQ-034 values regardless of HREADY.

Configuration
REQ-036 Macro RV32_ARB_FAIRNESS_EN, when defined: a saturating counter counts DMA beats accepted (HREADY=1, dma_htrans[1]=1) while in DMA and clears on leaving DMA; when the count is at least MAX_DMA_BEATS and cpu_req=1, the FSM moves to CPU at the next HREADY=1 edge with dma_htrans!=SEQ, even if dma_req=1. After that CPU transfer, normal priority applies again.
REQ-037 Macro RV32_ARB_FAIRNESS_EN, when undefined: no counter exists and DMA has strict priority with no limit.

Structure
REQ-038 Owner-state enum (IDLE/CPU/DMA) and HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11) belong in pkg_rv32_types.
REQ-039 Single module, no sub-modules; HRDATA, HRESP and HREADY fan out to both masters outside this block.

Verification
REQ-040 Lone CPU: cpu_req=1 at 0x100 NONSEQ -> cpu_grant=1 one cycle later, HADDR=0x100, dma_stall=0.
REQ-041 CPU and DMA request in the same cycle from IDLE -> dma_grant=1, dma_stall=1, cpu_grant=0.
REQ-042 CPU 4-beat INCR4 (NONSEQ, then 3 SEQ) with dma_req raised on beat 2 -> dma_grant=1 only after the 4th beat; no beat is lost.
REQ-043 DMA write to 0x2000 with HREADY=0 held for 3 cycles -> HWDATA = dma_hwdata throughout and dma_stall=1 until the data phase completes.
REQ-044 Fairness build, MAX_DMA_BEATS=16, DMA streaming single NONSEQ beats with cpu_req=1 -> after 16 beats the CPU is granted for one transfer, then the DMA is regranted.
REQ-045 rst=1 pulsed mid DMA burst -> next cycle state=IDLE, HTRANS=00, both grants 0, dma_stall=0.
